// File: rtl/fp_mul_booth_seq.sv
// Sequential radix-4 Booth significand multiplier: 24x24 -> exact 48-bit product, one digit per cycle.
// Optional macro BOOTH_ZERO_SKIP_EN: a zero operand bypasses BUSY and goes straight to DONE.
module fp_mul_booth_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] man_X,
  input  logic [23:0] man_Y,
  input  logic        sign_in,
  input  logic [2:0]  r_mode_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] frc_Z_full,
  output logic        norm_n,
  output logic        sign_Z,
  output logic [2:0]  r_mode
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] mx_q, mx_d;
  logic [23:0] my_q, my_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [49:0] acc_q, acc_d;
  logic        sign_cap_q, sign_cap_d;
  logic [2:0]  rmode_cap_q, rmode_cap_d;
  logic [47:0] frc_q, frc_d;
  logic        norm_q, norm_d;
  logic        sign_z_q, sign_z_d;
  logic [2:0]  rmode_q, rmode_d;

  // Multiplier zero-extended to 26 bits with the implicit y[-1]=0 below bit 0.
  logic [26:0] y_ext;
  logic [4:0]  sel_idx;
  logic [2:0]  trip;
  logic [25:0] pp;
  logic [49:0] term;
  logic [49:0] acc_sum;

  assign y_ext   = {2'b00, my_q, 1'b0};
  assign sel_idx = {cnt_q, 1'b0};
  assign trip    = y_ext[sel_idx +: 3];

  always_comb begin
    pp = 26'd0;
    case (trip)
      3'b001, 3'b010: pp = {2'b00, mx_q};
      3'b011:         pp = {1'b0, mx_q, 1'b0};
      3'b100:         pp = 26'd0 - {1'b0, mx_q, 1'b0};
      3'b101, 3'b110: pp = 26'd0 - {2'b00, mx_q};
      default:        pp = 26'd0;
    endcase
  end

  // Partial product weighted by 4^i; the sign extension keeps negative digits exact.
  assign term    = {{24{pp[25]}}, pp} << sel_idx;
  assign acc_sum = acc_q + term;

  always_comb begin
    state_d     = state_q;
    mx_d        = mx_q;
    my_d        = my_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sign_cap_d  = sign_cap_q;
    rmode_cap_d = rmode_cap_q;
    frc_d       = frc_q;
    norm_d      = norm_q;
    sign_z_d    = sign_z_q;
    rmode_d     = rmode_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mx_d        = man_X;
          my_d        = man_Y;
          sign_cap_d  = sign_in;
          rmode_cap_d = r_mode_in;
          acc_d       = 50'd0;
          cnt_d       = 4'd0;
          state_d     = S_BUSY;
`ifdef BOOTH_ZERO_SKIP_EN
          if ((man_X == 24'd0) || (man_Y == 24'd0)) begin
            state_d  = S_DONE;
            frc_d    = 48'd0;
            norm_d   = 1'b0;
            sign_z_d = sign_in;
            rmode_d  = r_mode_in;
          end
`endif
        end
      end
      S_BUSY: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd12) begin
          state_d  = S_DONE;
          cnt_d    = 4'd0;
          frc_d    = acc_sum[47:0];
          norm_d   = acc_sum[47];
          sign_z_d = sign_cap_q;
          rmode_d  = rmode_cap_q;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mx_q        <= 24'd0;
      my_q        <= 24'd0;
      cnt_q       <= 4'd0;
      acc_q       <= 50'd0;
      sign_cap_q  <= 1'b0;
      rmode_cap_q <= 3'd0;
      frc_q       <= 48'd0;
      norm_q      <= 1'b0;
      sign_z_q    <= 1'b0;
      rmode_q     <= 3'd0;
    end else begin
      state_q     <= state_d;
      mx_q        <= mx_d;
      my_q        <= my_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sign_cap_q  <= sign_cap_d;
      rmode_cap_q <= rmode_cap_d;
      frc_q       <= frc_d;
      norm_q      <= norm_d;
      sign_z_q    <= sign_z_d;
      rmode_q     <= rmode_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign frc_Z_full = frc_q;
  assign norm_n     = norm_q;
  assign sign_Z     = sign_z_q;
  assign r_mode     = rmode_q;

endmodule

// File: tb/tb_fp_mul_booth_seq.sv
// Bench for fp_mul_booth_seq: product/latency/handshake model checked every falling edge.
module tb_fp_mul_booth_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] man_X;
  logic [23:0] man_Y;
  logic        sign_in;
  logic [2:0]  r_mode_in;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] frc_Z_full;
  logic        norm_n;
  logic        sign_Z;
  logic [2:0]  r_mode;

  always #5 clk = ~clk;

  fp_mul_booth_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .man_X(man_X), .man_Y(man_Y), .sign_in(sign_in), .r_mode_in(r_mode_in),
    .out_valid(out_valid), .out_ready(out_ready), .frc_Z_full(frc_Z_full),
    .norm_n(norm_n), .sign_Z(sign_Z), .r_mode(r_mode)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;

  // Model state: at most one operation outstanding, result due at a known cycle.
  bit          pending = 0;
  int          due     = 0;
  logic [47:0] e_frc   = '0;
  logic        e_norm  = 1'b0;
  logic        e_sign  = 1'b0;
  logic [2:0]  e_rm    = '0;
  logic [63:0] prod;

  // Hand-computed values for directed cases.
  bit          lit_on   = 0;
  logic [47:0] lit_frc  = '0;
  logic        lit_norm = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    chk_cnt++;
    if (act === exp_v) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp_v, cyc);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pending = 0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_frc", 64'(frc_Z_full), 64'd0);
      chk("rst_norm", 64'(norm_n), 64'd0);
      chk("rst_sign", 64'(sign_Z), 64'd0);
      chk("rst_rmode", 64'(r_mode), 64'd0);
    end else begin
      chk("in_ready", 64'(in_ready), 64'(!pending));
      if (pending) chk("out_valid_timing", 64'(out_valid), 64'(cyc >= due));
      else         chk("out_valid_idle", 64'(out_valid), 64'd0);
      if (out_valid) begin
        chk("frc", 64'(frc_Z_full), 64'(e_frc));
        chk("norm", 64'(norm_n), 64'(e_norm));
        chk("sign", 64'(sign_Z), 64'(e_sign));
        chk("rmode", 64'(r_mode), 64'(e_rm));
        if (lit_on) begin
          chk("lit_frc", 64'(frc_Z_full), 64'(lit_frc));
          chk("lit_norm", 64'(norm_n), 64'(lit_norm));
        end
      end
      if (out_valid && out_ready) pending = 0;
      if (in_valid && in_ready) begin
        pending = 1;
        prod    = 64'(man_X) * 64'(man_Y);
        e_frc   = prod[47:0];
        e_norm  = (prod >= 64'h8000_0000_0000);
        e_sign  = sign_in;
        e_rm    = r_mode_in;
`ifdef BOOTH_ZERO_SKIP_EN
        due = ((man_X == 24'd0) || (man_Y == 24'd0)) ? cyc + 1 : cyc + 14;
`else
        due = cyc + 14;
`endif
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready) begin
      @(posedge clk); #1;
      n++;
      if (n > 100) begin
        $display("FAIL wait_in_ready: got in_ready=0 for 100 cycles, want 1");
        $fatal(1, "in_ready timeout");
      end
    end
  endtask

  task automatic issue(input logic [23:0] x, input logic [23:0] y, input logic s, input logic [2:0] rm);
    wait_ready();
    in_valid  = 1'b1;
    man_X     = x;
    man_Y     = y;
    sign_in   = s;
    r_mode_in = rm;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    man_X     = 24'($urandom);
    man_Y     = 24'($urandom);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid) begin
      @(posedge clk); #1;
      n++;
      if (n > 100) begin
        $display("FAIL wait_out_valid: got out_valid=0 for 100 cycles, want 1");
        $fatal(1, "out_valid timeout");
      end
    end
  endtask

  task automatic drain(input int hold, input int id);
    out_ready = 1'b0;
    wait_valid();
    repeat (hold) begin @(posedge clk); #1; end
    $display("txn %0d: Z=%012h norm=%0b sign=%0b rm=%0d", id, frc_Z_full, norm_n, sign_Z, r_mode);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic directed(input logic [23:0] x, input logic [23:0] y, input logic s,
                          input logic [2:0] rm, input logic [47:0] z, input logic nz, input int id);
    lit_on   = 1;
    lit_frc  = z;
    lit_norm = nz;
    issue(x, y, s, rm);
    drain(0, id);
    lit_on = 0;
  endtask

  initial begin
    logic [23:0] rx, ry;
    rst_n = 1'b0; in_valid = 1'b0; man_X = '0; man_Y = '0;
    sign_in = 1'b0; r_mode_in = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    directed(24'h800000, 24'h800000, 1'b0, 3'b000, 48'h400000000000, 1'b0, 1);
    directed(24'hC00000, 24'hC00000, 1'b1, 3'b010, 48'h900000000000, 1'b1, 2);
    directed(24'hFFFFFF, 24'hFFFFFF, 1'b0, 3'b001, 48'hFFFFFE000001, 1'b1, 3);
    directed(24'h000000, 24'hC90FDB, 1'b1, 3'b100, 48'h000000000000, 1'b0, 4);
    directed(24'hC90FDB, 24'h000000, 1'b0, 3'b011, 48'h000000000000, 1'b0, 5);

    // Backpressure with a competing request that must be ignored.
    lit_on = 1; lit_frc = 48'h900000000000; lit_norm = 1'b1;
    issue(24'hC00000, 24'hC00000, 1'b1, 3'b110);
    wait_valid();
    in_valid = 1'b1; man_X = 24'hABCDEF; man_Y = 24'h123456; sign_in = 1'b0; r_mode_in = 3'b111;
    repeat (5) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    drain(0, 6);
    lit_on = 0;

    // Asynchronous reset in the middle of BUSY.
    issue(24'hABCDEF, 24'hFEDCBA, 1'b1, 3'b101);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    directed(24'h800000, 24'h800000, 1'b0, 3'b000, 48'h400000000000, 1'b0, 7);

    for (int i = 0; i < 40; i++) begin
      rx = 24'($urandom) | 24'h800000;
      ry = 24'($urandom) | 24'h800000;
      if ($urandom_range(0, 7) == 0) rx = 24'd0;
      if ($urandom_range(0, 7) == 0) ry = 24'd0;
      if ($urandom_range(0, 9) == 0) rx = 24'hFFFFFF;
      issue(rx, ry, 1'($urandom), 3'($urandom));
      drain($urandom_range(0, 3), 100 + i);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/fp_mul_booth_seq.md
# fp_mul_booth_seq

Sequential radix-4 Booth mantissa multiplier for the single-precision FP multiplier. It sits directly upstream of the normalisation stage. It takes two 24-bit significands, with the hidden bit already resolved by the unpack logic, and produces the exact 48-bit product `frc_Z_full` plus the `norm_n` flag that the normaliser consumes. It retires one Booth digit per cycle behind a valid/ready handshake, and carries the sign and rounding-mode sideband alongside the operation.

## Interface
Parameters: none; all widths are fixed for binary32.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand set present.
- `in_ready` out 1: block can accept; high only in IDLE.
- `man_X` in 24: `{hidden, frc_X}` significand of X; the hidden bit is 0 for zero/subnormal inputs (flush-to-zero upstream).
- `man_Y` in 24: `{hidden, frc_Y}` significand of Y.
- `sign_in` in 1: `fp_X[31]^fp_Y[31]`, captured on accept.
- `r_mode_in` in 3: rounding mode, captured on accept.
- `out_valid` out 1: result held stable until consumed.
- `out_ready` in 1: downstream normaliser accepts.
- `frc_Z_full` out 48: exact unsigned product `man_X*man_Y`.
- `norm_n` out 1: equals `frc_Z_full[47]`.
- `sign_Z` out 1, `r_mode` out 3: captured sideband.

## Operation
- States:
  - IDLE: `in_ready=1`.
  - BUSY: iterating.
  - DONE: `out_valid=1`.
- IDLE→BUSY on `in_valid&&in_ready`.
  - Capture `man_X`, `man_Y`, `sign_in` and `r_mode_in`.
  - Clear the accumulator; digit counter = 0.
- Multiplier handling:
  - The multiplier is `man_Y`, zero-extended to 26 bits, with an implicit `y[-1]=0`.
  - This gives 13 radix-4 digits, i = 0..12.
- Digit i is taken from `{y[2i+1], y[2i], y[2i-1]}`:
  - 000 or 111 → 0
  - 001 or 010 → +1
  - 011 → +2
  - 100 → −2
  - 101 or 110 → −1
- Each BUSY cycle adds `digit_i*man_X*4^i` to the signed accumulator.
  - The accumulator is at least 50 bits, two's complement.
  - A shift-right formulation is permitted. The final value must equal the exact product.
- BUSY→DONE on the edge that processes digit 12 (counter == 12).
  - The final accumulator is always non-negative.
  - `frc_Z_full` = accumulator[47:0]; the upper bits are zero by construction.
- DONE→IDLE on `out_valid&&out_ready`.
- No accept occurs in the same cycle as a drain, so one operation is in flight at most.
- `in_valid` while not in IDLE is ignored; the upstream stage holds its data.
- Outputs `frc_Z_full`, `norm_n`, `sign_Z` and `r_mode` are registered and change only on the DONE entry edge.
- Reset (asynchronous, any state, including mid-BUSY):
  - State → IDLE and the in-flight operation is discarded.
  - Counter and accumulator cleared.
  - `out_valid=0`, `frc_Z_full=0`, `norm_n=0`, `sign_Z=0`, `r_mode=0`.
  - `in_ready=1` once reset is released.

## Timing
- Accept at edge E0; digits are processed on E1..E13; `out_valid` rises after E13.
- Latency is 13 cycles from the accept edge to `out_valid`.
- Minimum issue interval: 15 cycles.
  - 1 cycle accept, 13 cycles BUSY, 1 cycle DONE with `out_ready=1`.
  - `in_ready` rises on the cycle after the drain edge.
- Backpressure: DONE holds indefinitely while `out_ready=0`; all outputs are stable and `in_ready=0`.
- `in_ready` and `out_valid` are decoded from registered state only; there is no combinational path from `in_valid` or `out_ready`.

## Configuration
- `BOOTH_ZERO_SKIP_EN` defined:
  - On accept, if `man_X==0` or `man_Y==0`, go IDLE→DONE directly with `frc_Z_full=0` and `norm_n=0`.
  - `out_valid` rises 1 cycle after the accept edge.
  - Sideband is captured normally.
- `BOOTH_ZERO_SKIP_EN` undefined:
  - All operands take the full 13 BUSY cycles.
  - Results are identical; only latency differs.

## Test plan
- 1.0×1.0: `man_X=man_Y=24'h800000` → `frc_Z_full=48'h400000000000`, `norm_n=0`, `out_valid` 13 cycles after accept.
- 1.5×1.5: `24'hC00000×24'hC00000` → `frc_Z_full=48'h900000000000`, `norm_n=1`; with `sign_in=1`, `r_mode_in=3'b010` → `sign_Z=1`, `r_mode=3'b010`.
- Max significands: `24'hFFFFFF×24'hFFFFFF` → `48'hFFFFFE000001`, `norm_n=1`. This exercises the −1/+2 digit mix and the top digit.
- Zero operand, `man_X=0`, `man_Y=24'hC90FDB`:
  - Result `frc_Z_full=0`, `norm_n=0`.
  - `out_valid` at 1 cycle with `BOOTH_ZERO_SKIP_EN` defined, at 13 cycles without.
- Backpressure: hold `out_ready=0` for 5 cycles in DONE → outputs constant, `in_ready=0`, and a second `in_valid` is ignored. Raise `out_ready` → next cycle `in_ready=1`.
- Reset mid-operation: drop `rst_n` during BUSY cycle 6 → `out_valid=0` and `frc_Z_full=0` immediately. After release, `in_ready=1`, and a new `24'h800000×24'h800000` completes correctly.
